// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode sequencer: RUN/PAUSE/ADJ FSM, one prescaler, single-cycle strobes to the digit counter.
// Optional build macro STOPWATCH_CTRL_CLR_PAUSE_EN: a reset edge also parks the stopwatch in PAUSE.
module stopwatch_ctrl #(
  parameter int SEC_DIV = 100000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pause_btn,
  input  logic       reset_btn,
  input  logic       adj,
  input  logic [1:0] sel,
  output logic [1:0] state,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       inc_min,
  output logic       inc_sec,
  output logic       blink
);

  localparam int PW = $clog2(SEC_DIV);
  localparam logic [PW-1:0] FULL_V = PW'(SEC_DIV - 1);
  localparam logic [PW-1:0] HALF_V = PW'(SEC_DIV / 2 - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_PAUSE = 2'b01,
    ST_ADJ   = 2'b10
  } state_t;

  state_t        state_q, state_n;
  logic          run_saved, run_saved_n;
  logic          pause_prev, reset_prev;
  logic [PW-1:0] pcnt, pcnt_n;
  logic          cnt_en_n, cnt_clr_n, inc_min_n, inc_sec_n, blink_n;
  logic          pause_edge, reset_edge, full_tick, half_tick;
  logic          unused_sel_hi;

  assign unused_sel_hi = sel[1];

  assign pause_edge = pause_btn & ~pause_prev;
  assign reset_edge = reset_btn & ~reset_prev;
  assign full_tick  = (pcnt == FULL_V);
  assign half_tick  = (pcnt == HALF_V) | full_tick;

  always_comb begin
    state_n     = state_q;
    run_saved_n = run_saved;
    case (state_q)
      ST_RUN: begin
        if (adj) begin
          state_n     = ST_ADJ;
          run_saved_n = 1'b1;
        end else if (pause_edge) begin
          state_n = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (adj) begin
          state_n     = ST_ADJ;
          run_saved_n = 1'b0;
        end else if (pause_edge) begin
          state_n = ST_RUN;
        end
      end
      ST_ADJ: begin
        if (!adj) state_n = run_saved ? ST_RUN : ST_PAUSE;
      end
      default: state_n = ST_PAUSE;
    endcase
`ifdef STOPWATCH_CTRL_CLR_PAUSE_EN
    // A clear always leaves the stopwatch stopped, now or on leaving ADJ.
    if (reset_edge) begin
      if (state_q == ST_ADJ) begin
        run_saved_n = 1'b0;
        if (!adj) state_n = ST_PAUSE;
      end else if (state_n == ST_ADJ) begin
        run_saved_n = 1'b0;
      end else begin
        state_n = ST_PAUSE;
      end
    end
`endif
  end

  always_comb begin
    pcnt_n = pcnt;
    if (reset_edge)                pcnt_n = '0;
    else if (state_q != ST_PAUSE)  pcnt_n = full_tick ? '0 : pcnt + PW'(1);

    cnt_clr_n = reset_edge;
    cnt_en_n  = full_tick & (state_q == ST_RUN) & ~reset_edge;
    inc_sec_n = half_tick & (state_q == ST_ADJ) &  sel[0] & ~reset_edge;
    inc_min_n = half_tick & (state_q == ST_ADJ) & ~sel[0] & ~reset_edge;

    // Blink only runs while staying in ADJ; entering or leaving shows the field.
    blink_n = blink;
    if (state_n != ST_ADJ || state_q != ST_ADJ) blink_n = 1'b1;
    else if (half_tick && !reset_edge)          blink_n = ~blink;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_PAUSE;
      run_saved  <= 1'b0;
      pause_prev <= 1'b0;
      reset_prev <= 1'b0;
      pcnt       <= '0;
      cnt_en     <= 1'b0;
      cnt_clr    <= 1'b0;
      inc_min    <= 1'b0;
      inc_sec    <= 1'b0;
      blink      <= 1'b1;
    end else begin
      state_q    <= state_n;
      run_saved  <= run_saved_n;
      pause_prev <= pause_btn;
      reset_prev <= reset_btn;
      pcnt       <= pcnt_n;
      cnt_en     <= cnt_en_n;
      cnt_clr    <= cnt_clr_n;
      inc_min    <= inc_min_n;
      inc_sec    <= inc_sec_n;
      blink      <= blink_n;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with SEC_DIV=8: vector table plus hand sequences for multi-cycle cases.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pause_btn = 1'b0, reset_btn = 1'b0, adj = 1'b0;
  logic [1:0] sel = 2'b00;
  logic [1:0] state;
  logic       cnt_en, cnt_clr, inc_min, inc_sec, blink;

  int errors = 0;
  int checks = 0;

  stopwatch_ctrl #(.SEC_DIV(8)) dut (
    .clk(clk), .rst_n(rst_n), .pause_btn(pause_btn), .reset_btn(reset_btn),
    .adj(adj), .sel(sel), .state(state), .cnt_en(cnt_en), .cnt_clr(cnt_clr),
    .inc_min(inc_min), .inc_sec(inc_sec), .blink(blink)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       pause;
    logic       rst;
    logic       adj;
    logic [1:0] sel;
    logic [1:0] st;
    logic       en;
    logic       clr;
    logic       imin;
    logic       isec;
    logic       blk;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int first, n, nclr, k;
    logic found;

    tbl[0]  = '{1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 2; i < 14; i++)
      tbl[i] = '{1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset held, then released between edges.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", state, 1);
    chk("rst_blink", blink, 1);
    chk("rst_strobes", {cnt_en, cnt_clr, inc_min, inc_sec}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Start from PAUSE, run, first cnt_en after 8 counts, pause with pcnt held at 5.
    for (int i = 0; i < 15; i++) begin
      pause_btn = tbl[i].pause;
      reset_btn = tbl[i].rst;
      adj       = tbl[i].adj;
      sel       = tbl[i].sel;
      step();
      chk($sformatf("vec%0d_state", i), state, tbl[i].st);
      chk($sformatf("vec%0d_cnt_en", i), cnt_en, tbl[i].en);
      chk($sformatf("vec%0d_cnt_clr", i), cnt_clr, tbl[i].clr);
      chk($sformatf("vec%0d_inc", i), {inc_min, inc_sec}, {tbl[i].imin, tbl[i].isec});
      chk($sformatf("vec%0d_blink", i), blink, tbl[i].blk);
    end

    // Pause held 20 cycles, then resume: cnt_en after 3 cycles, one toggle for a 30-cycle hold.
    for (int i = 0; i < 20; i++) begin
      step();
      chk("hold_pause_state", state, 1);
      chk("hold_pause_en", cnt_en, 0);
    end
    pause_btn = 1'b0;
    step();
    chk("pause_release_state", state, 1);
    pause_btn = 1'b1;
    step();
    chk("resume_state", state, 0);
    first = -1;
    n = 0;
    for (int i = 1; i <= 30; i++) begin
      step();
      chk("hold_run_state", state, 0);
      if (cnt_en) begin
        n++;
        if (first < 0) first = i;
      end
    end
    chk("resume_first_en", first, 3);
    chk("run_en_count", n, 4);

    // Adjust seconds then minutes; pcnt is 3 here.
    pause_btn = 1'b0;
    adj = 1'b1;
    sel = 2'b01;
    step();
    chk("adj_entry_state", state, 2);
    chk("adj_entry_blink", blink, 1);
    chk("adj_entry_en", cnt_en, 0);
    for (int i = 1; i <= 16; i++) begin
      step();
      chk("adj_sec_state", state, 2);
      chk("adj_sec_inc", inc_sec, (i % 4 == 0) ? 1 : 0);
      chk("adj_sec_min", inc_min, 0);
      chk("adj_sec_en", cnt_en, 0);
      chk("adj_sec_blink", blink, 1 - ((i / 4) % 2));
    end
    sel = 2'b00;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("adj_min_inc", inc_min, (i % 4 == 0) ? 1 : 0);
      chk("adj_min_sec", inc_sec, 0);
      chk("adj_min_blink", blink, 1 - ((i / 4) % 2));
    end
    adj = 1'b0;
    step();
    chk("adj_exit_state", state, 0);
    chk("adj_exit_blink", blink, 1);

    // Clear at pcnt=7 in RUN, reset_btn held afterwards.
    step();
    step();
    reset_btn = 1'b1;
    step();
    chk("clr_pulse", cnt_clr, 1);
    chk("clr_supp_en", cnt_en, 0);
`ifdef STOPWATCH_CTRL_CLR_PAUSE_EN
    chk("clr_state", state, 1);
`else
    chk("clr_state", state, 0);
`endif
    first = -1;
    nclr = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (cnt_clr) nclr++;
      if (cnt_en && first < 0) first = i;
    end
    chk("clr_single", nclr, 0);
`ifdef STOPWATCH_CTRL_CLR_PAUSE_EN
    chk("clr_first_en", first, -1);
`else
    chk("clr_first_en", first, 8);
`endif
    reset_btn = 1'b0;

    // Pause and reset edges together from PAUSE.
`ifndef STOPWATCH_CTRL_CLR_PAUSE_EN
    pause_btn = 1'b1;
    step();
    chk("to_pause_state", state, 1);
`endif
    pause_btn = 1'b0;
    step();
    pause_btn = 1'b1;
    reset_btn = 1'b1;
    step();
    chk("dual_clr", cnt_clr, 1);
`ifdef STOPWATCH_CTRL_CLR_PAUSE_EN
    chk("dual_state", state, 1);
`else
    chk("dual_state", state, 0);
`endif
    pause_btn = 1'b0;
    reset_btn = 1'b0;
    step();
    chk("dual_clr_done", cnt_clr, 0);

    // adj and pause edge together from RUN: ADJ wins, exit back to RUN.
`ifdef STOPWATCH_CTRL_CLR_PAUSE_EN
    pause_btn = 1'b1;
    step();
    pause_btn = 1'b0;
    step();
`endif
    pause_btn = 1'b1;
    adj = 1'b1;
    step();
    chk("adj_pause_state", state, 2);
    adj = 1'b0;
    step();
    chk("adj_pause_exit", state, 0);
    chk("adj_pause_blink", blink, 1);

    // Pause edge ignored in ADJ, then async reset between edges.
    pause_btn = 1'b0;
    adj = 1'b1;
    step();
    pause_btn = 1'b1;
    step();
    chk("adj_ignore_pause", state, 2);
    found = 1'b0;
    k = 0;
    while (!found && k < 20) begin
      step();
      k++;
      if (!blink) found = 1'b1;
    end
    chk("adj_blink_low_seen", found, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_state", state, 1);
    chk("async_blink", blink, 1);
    chk("async_strobes", {cnt_en, cnt_clr, inc_min, inc_sec}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Mode sequencer for the stopwatch datapath. Takes debounced pause/reset levels and the ADJ/SEL switches, runs one prescaler off the board clock, and issues single-cycle count, clear and increment strobes to the digit counter, plus a blink flag to the display. It replaces the separate 1 Hz/2 Hz derived clocks: the counter and display run on `clk` and use these strobes as enables.

## Interface

- `SEC_DIV`, 100000000: `clk` cycles per second. Must be even and ≥ 4. Benches use 8.
- `clk`  in  1  board clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pause_btn`  in  1  debounced pause level, synchronous to `clk`.
- `reset_btn`  in  1  debounced reset level, synchronous to `clk`.
- `adj`  in  1  adjust-mode switch (level).
- `sel`  in  2  adjust select. `sel[0]`=1 selects seconds, 0 selects minutes. `sel[1]` is ignored.
- `state`  out  2  00 RUN, 01 PAUSE, 10 ADJ. 11 never occurs.
- `cnt_en`  out  1  one-cycle strobe: advance the count by 1 s.
- `cnt_clr`  out  1  one-cycle strobe: clear all digits to 00:00.
- `inc_min`  out  1  one-cycle strobe: increment the minutes field.
- `inc_sec`  out  1  one-cycle strobe: increment the seconds field.
- `blink`  out  1  display enable for the selected field. Held at 1 outside ADJ.

## Operation

- **Edge detect.** `pause_btn` and `reset_btn` each feed a previous-value register (reset value 0). An edge is `cur & ~prev`. Holding a level produces exactly one edge.
- **Prescaler `pcnt`.** Width is clog2(SEC_DIV). It counts 0..SEC_DIV-1 and wraps to 0.
  - It advances in RUN and ADJ and holds its value in PAUSE, so the partial second is kept.
  - A reset edge clears it to 0.
- **Ticks.** A full tick occurs at `pcnt==SEC_DIV-1`. A half tick occurs at `pcnt==SEC_DIV/2-1` or at a full tick.
- **FSM.** A `run_saved` bit records RUN versus PAUSE while in ADJ.
  - RUN → PAUSE on a pause edge.
  - PAUSE → RUN on a pause edge.
  - RUN or PAUSE → ADJ when `adj`=1. Entry records `run_saved`, and ADJ entry takes priority over a same-cycle pause edge.
  - ADJ → RUN or PAUSE (per `run_saved`) when `adj`=0.
  - Pause edges are ignored in ADJ.
- **Strobes** (registered, so each appears the cycle after its condition):
  - `cnt_en` = full tick & state==RUN.
  - `inc_sec` = half tick & state==ADJ & `sel[0]`.
  - `inc_min` = half tick & state==ADJ & ~`sel[0]`.
  - `cnt_clr` = reset edge, in any state.
- **Blink.** `blink` toggles on each half tick while in ADJ. It is forced to 1 on entry to ADJ and on leaving ADJ.
- **Simultaneous events.**
  - A reset edge suppresses a same-cycle tick: no `cnt_en`, `inc_*` or `blink` toggle that cycle.
  - A reset edge and a pause edge together: clear and toggle both happen.
  - A `sel` change mid-ADJ takes effect on the next half tick.
- **Reset values** (`rst_n`=0): `state`=PAUSE, `run_saved`=0, `pcnt`=0, `cnt_en`/`cnt_clr`/`inc_min`/`inc_sec`=0, `blink`=1. Assertion mid-operation takes effect immediately (asynchronous). The first edge is evaluated on the first `clk` after release.

## Timing

- Pause edge sampled at edge N → `state` updates at edge N+1.
- Reset edge sampled at edge N → `cnt_clr` high for one cycle after edge N+1, and `pcnt`=0 after edge N+1.
- The first `cnt_en` after a clear arrives SEC_DIV cycles later (if in RUN).
- In RUN, `cnt_en` period is exactly SEC_DIV cycles, pulse width 1 cycle.
- PAUSE→RUN resumes from the held `pcnt`. The next `cnt_en` arrives after SEC_DIV-1-`pcnt` more cycles, plus 1 cycle of registration.
- In ADJ, `inc_*` period is SEC_DIV/2 cycles.
- No strobe is ever wider than one cycle. At most one of `cnt_en`/`inc_min`/`inc_sec` is high in any cycle.

## Configuration

- `STOPWATCH_CTRL_CLR_PAUSE_EN`
  - Defined: a reset edge in RUN or PAUSE also forces `state`=PAUSE at the same edge as `cnt_clr`. A reset edge in ADJ sets `run_saved`=0, so exit from ADJ lands in PAUSE.
  - Undefined: a reset edge only clears; `state` and `run_saved` are unchanged.

## Test plan

- **Reset.** Hold `rst_n`=0, then release with inputs low → `state`=01, `blink`=1, all strobes 0. Pause edge → `state`=00 one cycle later, then `cnt_en` every 8 cycles (SEC_DIV=8).
- **Pause hold.** In RUN, pause edge at `pcnt`=5 → PAUSE. Hold 20 cycles, then pause edge → RUN. The next `cnt_en` arrives 3 cycles after resume (2 remaining counts + 1 registration). Holding `pause_btn` high for 30 cycles toggles state only once.
- **Adjust.** RUN, then `adj`=1 with `sel`=01 → `state`=10 and `inc_sec` every 4 cycles, no `cnt_en`. Switch `sel`=00 → `inc_min` instead. `blink` toggles every 4 cycles. `adj`=0 → `state`=00 and `blink`=1.
- **Clear.** Reset edge in RUN at `pcnt`=7 → single `cnt_clr`, no `cnt_en` that cycle, next `cnt_en` 8 cycles later. With `STOPWATCH_CTRL_CLR_PAUSE_EN` defined, `state`=01 instead.
- **Simultaneous edges.** Pause and reset edges in the same cycle from PAUSE → `cnt_clr` plus `state`=00 (macro undefined). `adj`=1 and pause edge together from RUN → `state`=10, and exit returns to RUN.
- **Async reset.** Assert `rst_n` mid-ADJ, between clock edges → outputs take their reset values immediately, with no clock edge needed.
